fetch_seq: RTL and testbench
============================

# fetch_seq

Instruction-fetch sequencer between the program counter register and the decode/execute stage of the 8-bit CPU. Each cycle it produces the next-PC value and halt flag the PC register consumes, fetches 1- or 2-byte instructions from program memory over a ready-handshake port, and presents a complete instruction to decode with a valid/ready handshake. Also handles taken branches and the HALT opcode.

## Interface
Parameters:
- `HALT_OP`, 8'hFF: opcode that stops fetch.
- `LONG_BIT`, 7: opcode bit that marks a 2-byte instruction (opcode + operand).

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `i_pc`  in  8  current PC from the PC register.
- `i_flush`  in  1  command-load pulse; the PC register clears to 0 on the same edge.
- `o_pc_add`  out  8  next-PC value for the PC register.
- `o_is_done`  out  1  halted; the PC register holds.
- `mem_req`  out  1  program-memory read request.
- `mem_addr`  out  8  read address; always equal to `i_pc`.
- `mem_rdy`  in  1  read complete; `mem_data` is valid in this cycle.
- `mem_data`  in  8  read data.
- `o_ir_valid`  out  1  instruction available to decode.
- `i_ir_ready`  in  1  decode accepts the instruction.
- `o_opcode`  out  8  opcode byte.
- `o_operand`  out  8  operand byte; 8'h00 for 1-byte instructions.
- `i_br_taken`  in  1  the accepted instruction is a taken branch.
- `i_br_target`  in  8  branch destination.

## Operation
- States: FETCH_OP, FETCH_ARG, ISSUE, HALT. Reset state is FETCH_OP.
- **FETCH_OP:** `mem_req`=1.
  - On `mem_rdy`: latch `o_opcode`=`mem_data`, clear `o_operand` to 0, drive `o_pc_add`=`i_pc`+1.
  - Next state: HALT if opcode==`HALT_OP`; else FETCH_ARG if opcode[`LONG_BIT`]=1; else ISSUE.
- **FETCH_ARG:** `mem_req`=1. On `mem_rdy`: latch `o_operand`, drive `o_pc_add`=`i_pc`+1, go to ISSUE.
- **ISSUE:** `o_ir_valid`=1, `mem_req`=0. `o_opcode` and `o_operand` are held stable until accepted.
  - Accept = `o_ir_valid` & `i_ir_ready`. On accept, go to FETCH_OP.
  - If `i_br_taken`=1 at accept, `o_pc_add`=`i_br_target`.
- **HALT:** `o_is_done`=1, `mem_req`=0. Sticky until `rst` or `i_flush`.
- **Default next PC:** `o_pc_add`=`i_pc` in every cycle not listed above (stall/hold).
- **PC arithmetic:** 8-bit modulo; 8'hFF+1 = 8'h00. A 2-byte instruction starting at 8'hFF takes its operand from 8'h00.
- **Flush:** `i_flush`=1 overrides every state.
  - That cycle: `mem_req`=0, `o_ir_valid`=0, `o_pc_add`=`i_pc`.
  - Next edge: state→FETCH_OP, `o_is_done`→0, `o_opcode`/`o_operand`→0. A pending `i_ir_ready` is ignored.
- **Reset:** state FETCH_OP; `o_opcode`=`o_operand`=0; `o_ir_valid`=0; `o_is_done`=0; `mem_req` forced to 0 while `rst`=1. `o_pc_add` follows `i_pc`.

## Timing
- `o_pc_add`, `mem_req`, `mem_addr` and `o_ir_valid` are combinational from state, `mem_rdy`, `i_ir_ready`, `i_br_taken` and `i_flush`.
- `o_opcode`, `o_operand` and state are registered.
- Memory handshake:
  - `mem_req` and `mem_addr` stay stable until `mem_rdy`.
  - `mem_rdy` may arrive in the same cycle as `mem_req` (zero wait) or any number of cycles later.
  - `mem_rdy` is ignored while `mem_req`=0.
- Latency with zero-wait memory:
  - 1-byte instruction: `o_ir_valid` rises 1 cycle after the opcode read.
  - 2-byte instruction: `o_ir_valid` rises 2 cycles after the opcode read.
  - Minimum issue interval: 2 cycles for 1-byte instructions, 3 cycles for 2-byte instructions.
- The PC advances exactly once per fetched byte; it never advances in ISSUE unless a branch is taken.
- Simultaneous `i_flush` and `mem_rdy`: flush wins and the read data is discarded.

## Configuration
- `FETCH_BRANCH_EN` defined: branch redirection as described above.
- Not defined: `i_br_taken` and `i_br_target` are ignored; on accept `o_pc_add`=`i_pc`, and fetch continues sequentially. The ports remain present.

## Test plan
- Reset, then zero-wait memory with 8'h01 at addr 0 and 8'h02 at addr 1, `i_ir_ready`=1 → issues opcode 01 with operand 00, then opcode 02 with operand 00; PC sequence 0,1,1,2.
- 2-byte: mem[5]=8'h85, mem[6]=8'h3C, PC=5 → issues opcode 85, operand 3C; PC ends at 7.
- Wait states: `mem_rdy` delayed 3 cycles → `mem_req` and `mem_addr` held stable, `o_pc_add`=`i_pc` each waiting cycle, PC unchanged.
- Backpressure plus branch: `i_ir_ready`=0 for 4 cycles with opcode and operand stable; then accept with `i_br_taken`=1, `i_br_target`=8'h40 → next fetch address 40 (without the macro: sequential address).
- HALT: mem[9]=8'hFF → `o_is_done`=1 and PC held at 10 indefinitely; `i_flush` pulse → `o_is_done`=0, fetch resumes at address 0.
- Wrap: 2-byte opcode 8'h90 at 8'hFF with operand at 8'h00 → operand read from addr 0, PC ends at 1. Async `rst` mid-FETCH_ARG → all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_seq.sv
// fetch_seq: instruction-fetch sequencer for the 8-bit CPU.
// Fetches 1- or 2-byte instructions from program memory, supplies the
// next-PC value and halt flag to the PC register, and issues complete
// instructions to decode.
// Optional feature macro: FETCH_BRANCH_EN (taken-branch redirection on accept).
//
// Handshakes:
//   memory : mem_req/mem_addr are held until mem_rdy; a read completes in
//            any cycle where mem_req & mem_rdy (zero-wait allowed). mem_rdy
//            is ignored while mem_req is low.
//   decode : o_ir_valid/i_ir_ready; an instruction is accepted in a cycle
//            where both are high. o_opcode/o_operand hold until accepted.
// i_flush overrides everything: no request, no valid, and a pending
// i_ir_ready or mem_rdy in that cycle is discarded.
module fetch_seq #(
  parameter logic [7:0] HALT_OP  = 8'hFF,
  parameter int         LONG_BIT = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_pc,
  input  logic       i_flush,
  output logic [7:0] o_pc_add,
  output logic       o_is_done,
  output logic       mem_req,
  output logic [7:0] mem_addr,
  input  logic       mem_rdy,
  input  logic [7:0] mem_data,
  output logic       o_ir_valid,
  input  logic       i_ir_ready,
  output logic [7:0] o_opcode,
  output logic [7:0] o_operand,
  input  logic       i_br_taken,
  input  logic [7:0] i_br_target,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    FETCH_OP  = 2'd0,
    FETCH_ARG = 2'd1,
    ISSUE     = 2'd2,
    HALT      = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_opcode;
  logic [7:0] r_operand;
  logic       r_is_done;

  logic       w_fetching;
  logic       w_mem_req;
  logic       w_rd_done;
  logic       w_ir_valid;
  logic       w_accept;
  logic       w_redirect;

  assign w_fetching = (r_state == FETCH_OP) || (r_state == FETCH_ARG);
  // Reset and flush both suppress the request so stray mem_rdy is ignored.
  assign w_mem_req  = w_fetching && !rst && !i_flush;
  assign w_rd_done  = w_mem_req && mem_rdy;
  assign w_ir_valid = (r_state == ISSUE) && !i_flush;
  assign w_accept   = w_ir_valid && i_ir_ready;

`ifdef FETCH_BRANCH_EN
  assign w_redirect = w_accept && i_br_taken;
`else
  // Branch inputs stay on the port list but have no effect in this build.
  assign w_redirect = 1'b0;
  logic w_unused_br;
  assign w_unused_br = ^{i_br_taken, i_br_target};
`endif

  // Next-PC select: +1 per completed byte read, branch target on a taken
  // accept, otherwise hold the current PC.
  always_comb begin
    o_pc_add = i_pc;
    if (w_rd_done) begin
      o_pc_add = i_pc + 8'd1;
    end else if (w_redirect) begin
`ifdef FETCH_BRANCH_EN
      o_pc_add = i_br_target;
`else
      o_pc_add = i_pc;
`endif
    end
  end

  // Fetch FSM with registered instruction bytes and halt flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH_OP;
      r_opcode  <= 8'h00;
      r_operand <= 8'h00;
      r_is_done <= 1'b0;
    end else if (i_flush) begin
      r_state   <= FETCH_OP;
      r_opcode  <= 8'h00;
      r_operand <= 8'h00;
      r_is_done <= 1'b0;
    end else begin
      case (r_state)
        FETCH_OP: begin
          if (mem_rdy) begin
            r_opcode  <= mem_data;
            r_operand <= 8'h00;
            if (mem_data == HALT_OP) begin
              r_state   <= HALT;
              r_is_done <= 1'b1;
            end else if (mem_data[LONG_BIT]) begin
              r_state <= FETCH_ARG;
            end else begin
              r_state <= ISSUE;
            end
          end
        end
        FETCH_ARG: begin
          if (mem_rdy) begin
            r_operand <= mem_data;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          if (i_ir_ready) begin
            r_state <= FETCH_OP;
          end
        end
        HALT: begin
          r_state <= HALT;
        end
        default: begin
          r_state <= FETCH_OP;
        end
      endcase
    end
  end

  assign mem_req     = w_mem_req;
  assign mem_addr    = i_pc;
  assign o_ir_valid  = w_ir_valid;
  assign o_opcode    = r_opcode;
  assign o_operand   = r_operand;
  assign o_is_done   = r_is_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fetch_seq.sv
// Testbench for fetch_seq: table of per-cycle vectors driven at the
// falling edge and checked 1 time unit later, plus hand-written sequences
// for address wrap and asynchronous reset during an operand fetch.
// The bench models the PC register and a program memory around the DUT.
module tb_fetch_seq;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [7:0] i_pc;
  logic       i_flush;
  logic [7:0] o_pc_add;
  logic       o_is_done;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_rdy;
  logic [7:0] mem_data;
  logic       o_ir_valid;
  logic       i_ir_ready;
  logic [7:0] o_opcode;
  logic [7:0] o_operand;
  logic       i_br_taken;
  logic [7:0] i_br_target;
  logic [1:0] o_dbg_state;

  fetch_seq dut (
    .clk        (clk),
    .rst        (rst),
    .i_pc       (i_pc),
    .i_flush    (i_flush),
    .o_pc_add   (o_pc_add),
    .o_is_done  (o_is_done),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdy    (mem_rdy),
    .mem_data   (mem_data),
    .o_ir_valid (o_ir_valid),
    .i_ir_ready (i_ir_ready),
    .o_opcode   (o_opcode),
    .o_operand  (o_operand),
    .i_br_taken (i_br_taken),
    .i_br_target(i_br_target),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- environment: program memory and PC register ----------------
  logic [7:0] mem [256];
  assign mem_data = mem[mem_addr];

  logic [7:0] tb_pc;
  logic       pc_force;
  logic [7:0] pc_force_val;
  assign i_pc = tb_pc;

  always @(posedge clk or posedge rst) begin
    if (rst)           tb_pc <= 8'h00;
    else if (pc_force) tb_pc <= pc_force_val;
    else if (i_flush)  tb_pc <= 8'h00;
    else               tb_pc <= o_pc_add;
  end

`ifdef FETCH_BRANCH_EN
  localparam logic [7:0] BR = 8'h40;
`else
  localparam logic [7:0] BR = 8'h04;
`endif

  // ---------------- vector table ----------------
  typedef struct {
    logic       flush;
    logic       rdy;
    logic       ready;
    logic       br;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic       req;
    logic [7:0] add;
    logic       valid;
    logic [7:0] op;
    logic [7:0] arg;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic fl, input logic rd, input logic ir, input logic br,
                      input logic [7:0] tgt, input logic [7:0] pc, input logic req,
                      input logic [7:0] add, input logic valid, input logic [7:0] op,
                      input logic [7:0] arg, input logic done);
    vec_t v;
    v.flush = fl; v.rdy = rd; v.ready = ir; v.br = br; v.tgt = tgt;
    v.pc = pc; v.req = req; v.add = add; v.valid = valid;
    v.op = op; v.arg = arg; v.done = done;
    vecs.push_back(v);
  endtask

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    n_vec++;
    chk({tag, " i_pc"},       i_pc,               v.pc);
    chk({tag, " mem_addr"},   mem_addr,           v.pc);
    chk({tag, " mem_req"},    {7'd0, mem_req},    {7'd0, v.req});
    chk({tag, " o_pc_add"},   o_pc_add,           v.add);
    chk({tag, " o_ir_valid"}, {7'd0, o_ir_valid}, {7'd0, v.valid});
    chk({tag, " o_opcode"},   o_opcode,           v.op);
    chk({tag, " o_operand"},  o_operand,          v.arg);
    chk({tag, " o_is_done"},  {7'd0, o_is_done},  {7'd0, v.done});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic fl, input logic rd, input logic ir,
                       input logic br, input logic [7:0] tgt);
    i_flush = fl; mem_rdy = rd; i_ir_ready = ir; i_br_taken = br; i_br_target = tgt;
  endtask

  vec_t h;

  initial begin
    // program image
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h00] = 8'h01;
    mem[8'h01] = 8'h02;
    mem[8'h02] = 8'h85;
    mem[8'h03] = 8'h3C;
    mem[8'h04] = 8'h05;
    mem[8'h05] = 8'hFF;
    mem[8'h40] = 8'h05;
    mem[8'h41] = 8'hFF;
    mem[8'hFF] = 8'h90;

    // fl rd ir br tgt    pc        req add       vld op     arg    done
    push(0, 1, 1, 0, 8'h00, 8'h00,    1, 8'h01,    0, 8'h00, 8'h00, 0); // opcode 01 at 0
    push(0, 1, 1, 0, 8'h00, 8'h01,    0, 8'h01,    1, 8'h01, 8'h00, 0); // issue 01
    push(0, 1, 1, 0, 8'h00, 8'h01,    1, 8'h02,    0, 8'h01, 8'h00, 0); // opcode 02 at 1
    push(0, 1, 1, 0, 8'h00, 8'h02,    0, 8'h02,    1, 8'h02, 8'h00, 0); // issue 02
    push(0, 1, 1, 0, 8'h00, 8'h02,    1, 8'h03,    0, 8'h02, 8'h00, 0); // opcode 85 at 2
    for (int k = 0; k < 3; k++)
      push(0, 0, 1, 0, 8'h00, 8'h03,  1, 8'h03,    0, 8'h85, 8'h00, 0); // operand wait states
    push(0, 1, 1, 0, 8'h00, 8'h03,    1, 8'h04,    0, 8'h85, 8'h00, 0); // operand 3C arrives
    for (int k = 0; k < 4; k++)
      push(0, 1, 0, 1, 8'h40, 8'h04,  0, 8'h04,    1, 8'h85, 8'h3C, 0); // backpressure, stable
    push(0, 1, 1, 1, 8'h40, 8'h04,    0, BR,       1, 8'h85, 8'h3C, 0); // accept + branch
    push(0, 1, 1, 0, 8'h00, BR,       1, BR+8'd1,  0, 8'h85, 8'h3C, 0); // fetch at branch dest
    push(0, 1, 1, 0, 8'h00, BR+8'd1,  0, BR+8'd1,  1, 8'h05, 8'h00, 0); // issue 05
    push(0, 1, 1, 0, 8'h00, BR+8'd1,  1, BR+8'd2,  0, 8'h05, 8'h00, 0); // HALT opcode read
    for (int k = 0; k < 2; k++)
      push(0, 1, 1, 1, 8'h40, BR+8'd2, 0, BR+8'd2, 0, 8'hFF, 8'h00, 1); // halted, PC held
    push(1, 1, 1, 0, 8'h00, BR+8'd2,  0, BR+8'd2,  0, 8'hFF, 8'h00, 1); // flush from HALT
    push(1, 1, 1, 0, 8'h00, 8'h00,    0, 8'h00,    0, 8'h00, 8'h00, 0); // flush beats mem_rdy
    push(0, 1, 1, 0, 8'h00, 8'h00,    1, 8'h01,    0, 8'h00, 8'h00, 0); // fetch resumes at 0
    push(0, 1, 0, 0, 8'h00, 8'h01,    0, 8'h01,    1, 8'h01, 8'h00, 0); // issue 01 again

    // reset phase (mem_rdy high to show it is ignored under reset)
    rst = 1'b1; pc_force = 1'b0; pc_force_val = 8'h00;
    drive(0, 1, 1, 0, 8'h00);
    @(negedge clk); #1;
    h = '{flush:0, rdy:1, ready:1, br:0, tgt:8'h00, pc:8'h00, req:0, add:8'h00,
          valid:0, op:8'h00, arg:8'h00, done:0};
    chk_vec("reset", h);
    chk("reset state", {6'd0, o_dbg_state}, 8'h00);
    drive(0, 0, 0, 0, 8'h00);
    rst = 1'b0;

    // table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].flush, vecs[i].rdy, vecs[i].ready, vecs[i].br, vecs[i].tgt);
      #1;
      chk_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // wrap: 2-byte opcode 90 at FF with operand at 00
    @(negedge clk);
    rst = 1'b1; #1; rst = 1'b0;
    drive(0, 0, 0, 0, 8'h00);
    pc_force = 1'b1; pc_force_val = 8'hFF;
    @(negedge clk);
    pc_force = 1'b0;
    drive(0, 1, 0, 0, 8'h00);
    #1;
    h = '{flush:0, rdy:1, ready:0, br:0, tgt:8'h00, pc:8'hFF, req:1, add:8'h00,
          valid:0, op:8'h00, arg:8'h00, done:0};
    chk_vec("wrap op", h);
    @(negedge clk); #1;
    h = '{flush:0, rdy:1, ready:0, br:0, tgt:8'h00, pc:8'h00, req:1, add:8'h01,
          valid:0, op:8'h90, arg:8'h00, done:0};
    chk_vec("wrap arg", h);
    chk("wrap state", {6'd0, o_dbg_state}, 8'h01);
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00);
    #1;
    h = '{flush:0, rdy:0, ready:0, br:0, tgt:8'h00, pc:8'h01, req:0, add:8'h01,
          valid:1, op:8'h90, arg:8'h01, done:0};
    chk_vec("wrap issue", h);

    // async reset while in FETCH_ARG
    i_ir_ready = 1'b1; pc_force = 1'b1; pc_force_val = 8'hFF;
    @(negedge clk);
    pc_force = 1'b0;
    drive(0, 1, 0, 0, 8'h00);
    @(negedge clk);
    drive(0, 0, 0, 0, 8'h00);
    #1;
    chk("pre-rst state", {6'd0, o_dbg_state}, 8'h01);
    chk("pre-rst opcode", o_opcode, 8'h90);
    #1; rst = 1'b1; mem_rdy = 1'b1; #1;
    h = '{flush:0, rdy:1, ready:0, br:0, tgt:8'h00, pc:8'h00, req:0, add:8'h00,
          valid:0, op:8'h00, arg:8'h00, done:0};
    chk_vec("async rst", h);
    chk("async rst state", {6'd0, o_dbg_state}, 8'h00);
    mem_rdy = 1'b0;
    #1; rst = 1'b0;
    @(negedge clk);
    drive(0, 1, 0, 0, 8'h00);
    #1;
    h = '{flush:0, rdy:1, ready:0, br:0, tgt:8'h00, pc:8'h00, req:1, add:8'h01,
          valid:0, op:8'h00, arg:8'h00, done:0};
    chk_vec("post rst", h);

    // report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
